// File: rtl/mem_bus_pkg.sv
// Shared types and default address map for the data-side memory bus.
//   bus_state_t   : controller FSM states
//   DEFAULT_*_W   : default bus widths
//   *_BASE / MASK : default slave regions (4 KiB each)
package mem_bus_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 32;

  localparam logic [31:0] DMEM_BASE   = 32'h0000_0000;
  localparam logic [31:0] SPRITE_BASE = 32'h0000_1000;
  localparam logic [31:0] UART_BASE   = 32'h0000_2000;
  localparam logic [31:0] REGION_MASK = 32'hFFFF_F000;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } bus_state_t;

endpackage

// File: rtl/mem_bus_decoder.sv
// Combinational base/mask address decoder.
//   addr_i   : CPU byte address
//   hit_o    : some slave region matches
//   match_o  : one-hot select of the winning slave (lowest index on overlap)
//   idx_o    : binary index of the winning slave
//   offset_o : word offset of addr_i within the winning region
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] BASE = {UART_BASE, SPRITE_BASE, DMEM_BASE},
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] MASK = {REGION_MASK, REGION_MASK, REGION_MASK}
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  hit_o,
  output logic [NUM_SLAVES-1:0] match_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [ADDR_W-3:0]     offset_o
);

  always_comb begin
    hit_o    = 1'b0;
    match_o  = '0;
    idx_o    = '0;
    offset_o = '0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & MASK[i]) == BASE[i]) begin
        hit_o      = 1'b1;
        match_o    = '0;
        match_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
        // Regions are word aligned, so the word offset needs no borrow from bits [1:0].
        offset_o   = addr_i[ADDR_W-1:2] - BASE[i][ADDR_W-1:2];
      end
    end
  end

endmodule

// File: rtl/mem_bus_controller.sv
// Routes single CPU load/store transactions to NUM_SLAVES memory-mapped slaves.
//   clk, reset        : clock, asynchronous active-low reset
//   req_i/we_i/addr_i/wdata_i : CPU request, held until ready_o
//   rdata_o/ready_o/err_o     : one-cycle completion pulse with data / error flag
//   sel_o/we_o/addr_o/wdata_o : one-hot slave select and registered slave command
//   rdata_i/ack_i             : per-slave read data slices and completion bits
// Unmapped or misaligned requests complete with err_o without selecting a slave;
// a selected slave that never acks is abandoned after TIMEOUT cycles with err_o.
module mem_bus_controller
  import mem_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] BASE = {UART_BASE, SPRITE_BASE, DMEM_BASE},
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] MASK = {REGION_MASK, REGION_MASK, REGION_MASK},
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         ready_o,
  output logic                         err_o,
  output logic [NUM_SLAVES-1:0]        sel_o,
  output logic                         we_o,
  output logic [ADDR_W-3:0]            addr_o,
  output logic [DATA_W-1:0]            wdata_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] rdata_i,
  input  logic [NUM_SLAVES-1:0]        ack_i
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  bus_state_t state_q, state_d;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  we_lat_q, we_lat_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  we_q, we_d;
  logic [ADDR_W-3:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_match;
  logic [IDX_W-1:0]      dec_idx;
  logic [ADDR_W-3:0]     dec_offset;

  logic                  ack_sel;
  logic [DATA_W-1:0]     rdata_sel;

  mem_bus_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .BASE       (BASE),
    .MASK       (MASK)
  ) u_decoder (
    .addr_i   (addr_i),
    .hit_o    (dec_hit),
    .match_o  (dec_match),
    .idx_o    (dec_idx),
    .offset_o (dec_offset)
  );

  // Only the latched slave's ack and data matter; stray acks elsewhere are ignored.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (IDX_W'(i) == idx_q) begin
        ack_sel   = ack_i[i];
        rdata_sel = rdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we_lat_d = we_lat_q;
    cnt_d    = cnt_q;
    sel_d    = '0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_lat_d = we_i;
          wdata_d  = wdata_i;
          idx_d    = dec_idx;
          addr_d   = dec_offset;
          rdata_d  = '0;
          if (!dec_hit || (addr_i[1:0] != 2'b00)) begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
            sel_d   = dec_match;
            we_d    = we_i;
          end
        end
      end

      ACCESS: begin
        // Ack is checked first so it wins over a coinciding timeout.
        if (ack_sel) begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = we_lat_q ? '0 : rdata_sel;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          sel_d = sel_q;
          we_d  = we_lat_q;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      we_lat_q <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      we_lat_q <= we_lat_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign sel_o   = sel_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign ready_o = ready_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
module tb_mem_bus_controller;

  localparam int NS = 3;
  localparam int TO = 16;

  logic          clk;
  logic          reset;
  logic          req_i;
  logic          we_i;
  logic [31:0]   addr_i;
  logic [31:0]   wdata_i;
  logic [31:0]   rdata_o;
  logic          ready_o;
  logic          err_o;
  logic [NS-1:0] sel_o;
  logic          we_o;
  logic [29:0]   addr_o;
  logic [31:0]   wdata_o;
  logic [NS*32-1:0] rdata_i;
  logic [NS-1:0] ack_i;

  logic [31:0] slave_data [NS];
  int          ack_wait [NS];
  logic [NS-1:0] stray_mask;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] bases [NS];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          w0, w1, w2;
    logic [2:0]  stray;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [2:0]  e_sel;
    logic [29:0] e_off;
    int          e_selcyc;
  } vec_t;

  mem_bus_controller dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .ready_o (ready_o),
    .err_o   (err_o),
    .sel_o   (sel_o),
    .we_o    (we_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .rdata_i (rdata_i),
    .ack_i   (ack_i)
  );

  assign rdata_i = {slave_data[2], slave_data[1], slave_data[0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave responder: acks after ack_wait[i] extra cycles of select; -1 never acks.
  initial begin
    int sel_cyc;
    sel_cyc = 0;
    ack_i = '0;
    forever begin
      @(negedge clk);
      ack_i = stray_mask & ~sel_o;
      if (sel_o != '0) begin
        for (int i = 0; i < NS; i++)
          if (sel_o[i] && ack_wait[i] == sel_cyc) ack_i[i] = 1'b1;
        sel_cyc++;
      end else begin
        sel_cyc = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(logic [31:0] addr, logic we, logic [31:0] wd, int w0, int w1,
                              int w2, logic [2:0] stray, int lat, logic err, logic [31:0] rd,
                              logic [2:0] sel, logic [29:0] off, int selcyc);
    vec_t v;
    v.addr = addr; v.we = we; v.wdata = wd; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.stray = stray;
    v.e_lat = lat; v.e_err = err; v.e_rdata = rd; v.e_sel = sel; v.e_off = off;
    v.e_selcyc = selcyc;
    return v;
  endfunction

  // Transaction-level reference: region lookup by address range, then latency by wait count.
  function automatic vec_t model(vec_t v);
    vec_t r;
    int idx;
    int w;
    logic [31:0] diff;
    r = v;
    idx = -1;
    for (int i = 0; i < NS; i++)
      if (idx < 0 && v.addr >= bases[i] && v.addr < bases[i] + 32'h1000) idx = i;
    r.e_off = '0;
    if (idx < 0 || (v.addr % 4) != 0) begin
      r.e_lat = 1; r.e_err = 1'b1; r.e_rdata = '0; r.e_sel = '0; r.e_selcyc = 0;
    end else begin
      w = (idx == 0) ? v.w0 : (idx == 1) ? v.w1 : v.w2;
      r.e_sel = 3'b001 << idx;
      diff = v.addr - bases[idx];
      r.e_off = diff[31:2];
      if (w < 0 || w >= TO) begin
        r.e_lat = TO + 1; r.e_err = 1'b1; r.e_rdata = '0; r.e_selcyc = TO;
      end else begin
        r.e_lat = w + 2; r.e_err = 1'b0; r.e_selcyc = w + 1;
        r.e_rdata = v.we ? 32'h0 : slave_data[idx];
      end
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int n;
    int selcyc;
    int sel_bad;
    bit got;
    @(negedge clk);
    check({tag, ".idle_ready"}, {31'b0, ready_o}, 32'h0);
    ack_wait[0] = v.w0; ack_wait[1] = v.w1; ack_wait[2] = v.w2;
    stray_mask = v.stray;
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata;
    n = 0; selcyc = 0; sel_bad = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        // Request fields must be ignored once accepted.
        addr_i = $urandom; we_i = $urandom_range(0, 1); wdata_i = $urandom;
      end
      if (sel_o != '0) begin
        selcyc++;
        if (sel_o !== v.e_sel || addr_o !== v.e_off || we_o !== v.we ||
            (v.we && wdata_o !== v.wdata)) sel_bad++;
      end
      if (ready_o) got = 1'b1;
    end
    req_i = 1'b0;
    stray_mask = '0;
    check({tag, ".lat"}, n, v.e_lat);
    check({tag, ".err"}, {31'b0, err_o}, {31'b0, v.e_err});
    check({tag, ".rdata"}, rdata_o, v.e_rdata);
    check({tag, ".sel_cycles"}, selcyc, v.e_selcyc);
    check({tag, ".sel_stable"}, sel_bad, 0);
  endtask

  initial begin
    vec_t tbl [7];
    int   seen_ready;

    bases[0] = 32'h0000_0000; bases[1] = 32'h0000_1000; bases[2] = 32'h0000_2000;
    slave_data[0] = 32'hA5A5_0000;
    slave_data[1] = 32'hDEAD_BEEF;
    slave_data[2] = 32'h2222_3333;
    for (int i = 0; i < NS; i++) ack_wait[i] = -1;
    stray_mask = '0;
    reset = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;

    //         addr          we wdata         w0  w1  w2 stray  lat err rdata         sel     off sc
    tbl[0] = mk(32'h0000_1008, 0, 32'h0,         0,  0,  0, 3'b000, 2, 0, 32'hDEAD_BEEF, 3'b010, 2, 1);
    tbl[1] = mk(32'h0000_0010, 1, 32'h1234_5678, 3,  0,  0, 3'b000, 5, 0, 32'h0,         3'b001, 4, 4);
    tbl[2] = mk(32'h0000_5000, 0, 32'h0,         0,  0,  0, 3'b000, 1, 1, 32'h0,         3'b000, 0, 0);
    tbl[3] = mk(32'h0000_1002, 0, 32'h0,         0,  0,  0, 3'b000, 1, 1, 32'h0,         3'b000, 0, 0);
    tbl[4] = mk(32'h0000_2000, 0, 32'h0,         0,  0, -1, 3'b000, 17, 1, 32'h0,        3'b100, 0, 16);
    tbl[5] = mk(32'h0000_1004, 0, 32'h0,         0, 15,  0, 3'b001, 17, 0, 32'hDEAD_BEEF, 3'b010, 1, 16);
    tbl[6] = mk(32'h0000_0000, 0, 32'h0,         0,  0,  0, 3'b000, 2, 0, 32'hA5A5_0000, 3'b001, 0, 1);

    repeat (2) @(negedge clk);
    check("rst.sel",   {29'b0, sel_o}, 32'h0);
    check("rst.ready", {31'b0, ready_o}, 32'h0);
    check("rst.err",   {31'b0, err_o}, 32'h0);
    check("rst.we",    {31'b0, we_o}, 32'h0);
    check("rst.rdata", rdata_o, 32'h0);
    check("rst.addr",  {2'b0, addr_o}, 32'h0);
    check("rst.wdata", wdata_o, 32'h0);
    reset = 1'b1;

    for (int k = 0; k < 7; k++) run_txn(tbl[k], $sformatf("vec%0d", k));

    // Reset in the second ACCESS cycle aborts the transaction with no response.
    @(negedge clk);
    for (int i = 0; i < NS; i++) ack_wait[i] = -1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0004;
    @(negedge clk);
    @(negedge clk);
    check("abort.sel_before", {29'b0, sel_o}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("abort.sel",   {29'b0, sel_o}, 32'h0);
    check("abort.ready", {31'b0, ready_o}, 32'h0);
    check("abort.err",   {31'b0, err_o}, 32'h0);
    @(negedge clk);
    req_i = 1'b0;
    reset = 1'b1;
    seen_ready = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready_o) seen_ready++;
    end
    check("abort.no_ready", seen_ready, 0);
    run_txn(tbl[6], "post_reset");

    // Randomised transactions against the reference model.
    for (int k = 0; k < 60; k++) begin
      vec_t v;
      logic [31:0] region [5];
      int waits [8];
      region[0] = 32'h0; region[1] = 32'h1000; region[2] = 32'h2000;
      region[3] = 32'h3000; region[4] = 32'hFFFF_F000;
      waits[0] = -1; waits[1] = 0; waits[2] = 0; waits[3] = 1;
      waits[4] = 2; waits[5] = 3; waits[6] = 15; waits[7] = 16;
      for (int i = 0; i < NS; i++) slave_data[i] = $urandom;
      v.addr = region[$urandom_range(0, 4)] + 32'($urandom_range(0, 1023)) * 4;
      if ($urandom_range(0, 7) == 0) v.addr = v.addr + 32'($urandom_range(1, 3));
      v.we = 1'($urandom_range(0, 1));
      v.wdata = $urandom;
      v.w0 = waits[$urandom_range(0, 7)];
      v.w1 = waits[$urandom_range(0, 7)];
      v.w2 = waits[$urandom_range(0, 7)];
      v.stray = 3'($urandom_range(0, 7));
      v = model(v);
      run_txn(v, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
